// File: rtl/top_pkg.sv
// Shared definitions for the CPU execution-control stage: FSM encodings and
// default timing parameters.
package top_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRun    = 2'b01,
        StStep   = 2'b10,
        StHalted = 2'b11
    } state_e;

    localparam int unsigned DefDiv      = 50_000_000;
    localparam int unsigned DefDbCycles = 1_000_000;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability-count debouncer and a
// registered one-cycle pulse on the debounced rising edge.
module btn_debounce
    import top_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DefDbCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = cnt_width(DB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            prev_q;
    logic            rise_q, rise_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        // Count consecutive disagreeing samples; any agreeing sample restarts.
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        rise_d = level_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Execution control for the single-cycle core: issues a one-cycle clock enable
// periodically (run), once per debounced button press (step), or never (halted).
module cpu_step_ctrl
    import top_pkg::*;
#(
    parameter int unsigned DIV       = DefDiv,
    parameter int unsigned DB_CYCLES = DefDbCycles,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_run,
    input  logic             btn_step,
    input  logic             halt,
    output logic             cpu_ce,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       state
);

    localparam int unsigned DivW = cnt_width(DIV);
    localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);

    state_e           state_q, state_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;
    logic             run_meta_q, run_s_q;
    logic             step_req;
    logic             btn_level_unused;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_step),
        .level(btn_level_unused),
        .rise (step_req)
    );

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        ce_d    = 1'b0;
        cnt_d   = ce_q ? cnt_q + CNT_W'(1) : cnt_q;

        unique case (state_q)
            StIdle: begin
                if (halt) begin
                    state_d = StHalted;
                end else if (run_s_q) begin
                    state_d = StRun;
                    div_d   = '0;
                end else if (step_req) begin
                    state_d = StStep;
                    ce_d    = 1'b1;
                end
            end
            StRun: begin
                // Halt and switch-off both pre-empt a divider pulse due on this edge.
                if (halt) begin
                    state_d = StHalted;
                end else if (!run_s_q) begin
                    state_d = StIdle;
                    div_d   = '0;
                end else if (div_q == DivMax) begin
                    div_d = '0;
                    ce_d  = 1'b1;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end
            StStep: begin
                state_d = halt ? StHalted : StIdle;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            cnt_q      <= '0;
            ce_q       <= 1'b0;
            run_meta_q <= 1'b0;
            run_s_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            ce_q       <= ce_d;
            run_meta_q <= sw_run;
            run_s_q    <= run_meta_q;
        end
    end

    assign cpu_ce     = ce_q;
    assign step_count = cnt_q;
    assign state      = state_q;

endmodule
